// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a DMA/loader port.
// Define DMEM_ARB_FAIR_EN to enable the DMA starvation counter; otherwise the pipeline always wins.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        stall_p,
  output logic        p_rvalid,
  output logic [31:0] p_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_PIPE = 2'd1,
    R_DMA  = 2'd2
  } rstate_t;

  rstate_t state_r;
  logic    p_gnt_s;
  logic    d_gnt_s;
  logic    force_dma_s;

`ifdef DMEM_ARB_FAIR_EN
  logic [3:0] starve_r;

  // Count consecutive cycles the DMA waits behind the pipeline (saturating)
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_r <= 4'd0;
    end else if (!d_req || d_gnt_s) begin
      starve_r <= 4'd0;
    end else if (starve_r != 4'hF) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  assign force_dma_s = d_req & (starve_r >= LIMIT_C);
`else
  logic unused_limit_s;

  assign unused_limit_s = ^LIMIT_C;
  assign force_dma_s    = 1'b0;
`endif

  // Grant decision: pipeline first unless the DMA has waited long enough
  always_comb begin
    p_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst) begin
      p_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (p_req && !force_dma_s) begin
      p_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      p_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Route the granted requester onto the memory port; idle drives all zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (p_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (d_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
    end
  end

  assign stall_p = p_req & ~p_gnt_s;
  assign d_gnt   = d_gnt_s;

  // Read-owner FSM: remembers who issued the load whose data arrives next cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= R_NONE;
    end else if (p_gnt_s && !p_we) begin
      state_r <= R_PIPE;
    end else if (d_gnt_s && !d_we) begin
      state_r <= R_DMA;
    end else begin
      state_r <= R_NONE;
    end
  end

  assign p_rvalid = (state_r == R_PIPE);
  assign d_rvalid = (state_r == R_DMA);
  assign p_rdata  = p_rvalid ? mem_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        stall_p, p_rvalid, d_gnt, d_rvalid;
  logic [31:0] p_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .stall_p(stall_p), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        p;
    logic        d;
    logic [31:0] data;
  } ret_t;

  ret_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_model [16];
  logic [15:0] mem_valid = 16'h0;
  logic [31:0] ref_mem   [16];

  function automatic logic [31:0] init_pat(input int i);
    if (i == 5) return 32'hA5A5A5A5;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Synchronous-read memory: data appears the cycle after a read enable
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_model[mem_addr[5:2]] <= mem_wdata;
        mem_valid[mem_addr[5:2]] <= 1'b1;
      end else begin
        mem_rdata <= mem_valid[mem_addr[5:2]] ? mem_model[mem_addr[5:2]]
                                               : init_pat(int'(mem_addr[5:2]));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: drive, check returns of the previous load and this cycle's grant, schedule next return
  task automatic step(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic eg_p, input logic eg_d, input logic drop_rst);
    ret_t e;
    ret_t nx;
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #3;
    e = '0;
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check("p_rvalid", {31'h0, p_rvalid}, {31'h0, e.p});
    check("d_rvalid", {31'h0, d_rvalid}, {31'h0, e.d});
    check("p_rdata", p_rdata, e.p ? e.data : 32'h0);
    check("d_rdata", d_rdata, e.d ? e.data : 32'h0);
    check("stall_p", {31'h0, stall_p}, {31'h0, pr & ~eg_p});
    check("d_gnt", {31'h0, d_gnt}, {31'h0, eg_d});
    check("mem_en", {31'h0, mem_en}, {31'h0, eg_p | eg_d});
    check("mem_we", {31'h0, mem_we}, {31'h0, eg_p ? pw : (eg_d ? dw : 1'b0)});
    check("mem_addr", mem_addr, eg_p ? pa : (eg_d ? da : 32'h0));
    check("mem_wdata", mem_wdata, eg_p ? pd : (eg_d ? dd : 32'h0));
    nx = '0;
    if (drop_rst) begin
      rst = 1'b0;
      #1;
      check("rst_mem_en", {31'h0, mem_en}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_stall_p", {31'h0, stall_p}, {31'h0, pr});
      check("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
    end else if (eg_p) begin
      if (pw) ref_mem[pa[5:2]] = pd;
      else nx = {1'b1, 1'b0, ref_mem[pa[5:2]]};
    end else if (eg_d) begin
      if (dw) ref_mem[da[5:2]] = dd;
      else nx = {1'b0, 1'b1, ref_mem[da[5:2]]};
    end else begin
      nx = '0;
    end
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic fair_k;
    rst = 1'b0;
    p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_pat(i);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);

    // Reset held: both request, nothing granted
    step(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Pipeline load of 0x14, then its return
    step(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // DMA store, then DMA load reading it back
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);

    // Pipeline store; contended cycle where the DMA store is blocked
    step(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 1'b0);

    // Both loads held for six cycles
    for (int k = 1; k <= 6; k++) begin
`ifdef DMEM_ARB_FAIR_EN
      fair_k = (k == 5);
`else
      fair_k = 1'b0;
`endif
      step(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, ~fair_k, fair_k, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Alternating pipeline / DMA loads back to back
    step(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Load granted, then reset asserted before the edge: the return is dropped
    step(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive blocked DMA cycles before the DMA port gets forced priority (range 1-15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-004 p_req  in  1  pipeline MEM-stage access request.
REQ-005 p_we  in  1  pipeline write enable (1 = store, 0 = load).
REQ-006 p_addr  in  32  pipeline byte address (ALU result).
REQ-007 p_wdata  in  32  pipeline store data.
REQ-008 stall_p  out  1  pipeline request blocked this cycle; the MEM stage holds its request.
REQ-009 p_rvalid  out  1  pipeline load data valid.
REQ-010 p_rdata  out  32  pipeline load data.
REQ-011 d_req, d_we  in  1 each  DMA/loader request and write enable.
REQ-012 d_addr, d_wdata  in  32 each  DMA address and store data.
REQ-013 d_gnt  out  1  DMA request accepted this cycle.
REQ-014 d_rvalid  out  1 / d_rdata  out  32  DMA load return.
REQ-015 mem_en, mem_we  out  1 each  data memory port enable and write.
REQ-016 mem_addr, mem_wdata  out  32 each / mem_rdata  in  32  memory port; synchronous read, data valid one cycle after mem_en & ~mem_we.

Function
REQ-017 At most one requester is granted per cycle; the grant decision is combinational in the request cycle.
REQ-018 Granted requester's we/addr/wdata drive mem_we/mem_addr/mem_wdata unmodified; mem_en = 1 only when some grant is active.
REQ-019 Idle (no grant): mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-020 stall_p = p_req & ~p_gnt; d_gnt is high only on the DMA grant cycle.
REQ-021 Read-owner FSM, states R_NONE, R_PIPE, R_DMA: next state = R_PIPE on granted pipeline load, R_DMA on granted DMA load, otherwise R_NONE; writes always lead to R_NONE.
REQ-022 p_rvalid = (state == R_PIPE), d_rvalid = (state == R_DMA); load-to-rvalid latency is exactly 1 cycle.
REQ-023 p_rdata/d_rdata = mem_rdata when their rvalid is high, else 32'h0.
REQ-024 Only one requester: it is granted the same cycle.
REQ-025 Both request, default: pipeline granted, DMA blocked.
REQ-026 Back-to-back grants are allowed every cycle; a new load may be issued in the same cycle that the previous load's rvalid is high.

Reset
REQ-027 While rst = 0 at a rising edge: FSM -> R_NONE, starvation counter -> 0.
REQ-028 While rst = 0, all grants are suppressed: mem_en = 0, mem_we = 0, stall_p = p_req, d_gnt = 0.
REQ-029 After reset, both rvalid outputs are 0 with rdata = 0; a load issued the cycle before reset asserts never returns rvalid.

Configuration
REQ-030 Macro DMEM_ARB_FAIR_EN defined: a 4-bit starvation counter counts cycles with d_req & ~d_gnt and clears on d_gnt or ~d_req; once count >= STARVE_LIMIT, the DMA port wins the next contended cycle (pipeline stalls) and the counter clears.
REQ-031 Macro DMEM_ARB_FAIR_EN undefined: strict pipeline priority; no counter; the DMA may starve indefinitely.

Verification
REQ-032 Pipeline load only, p_addr = 32'h14 with mem returning 32'hA5A5A5A5 -> mem_en = 1 and stall_p = 0 in cycle N; p_rvalid = 1 with p_rdata = 32'hA5A5A5A5 in cycle N+1; d_rvalid = 0.
REQ-033 DMA store d_addr = 32'h8, d_wdata = 32'hDEADBEEF, p_req = 0 -> d_gnt = 1, mem_we = 1, mem_addr = 32'h8 same cycle; no rvalid next cycle.
REQ-034 Both loads held for 6 cycles, macro undefined -> pipeline granted every cycle; d_gnt = 0 throughout; stall_p = 0.
REQ-035 Same stimulus with DMEM_ARB_FAIR_EN and STARVE_LIMIT = 4 -> d_gnt = 1 and stall_p = 1 in cycle 5 only; d_rvalid = 1 in cycle 6.
REQ-036 Pipeline load granted, rst driven to 0 for the next edge -> p_rvalid stays 0; mem_en = 0 while rst = 0.
REQ-037 Alternating pipeline load/DMA load on consecutive cycles -> rvalid alternates p, d, p with correct mem_rdata routing and no lost or duplicated return.
